cache_axi_rd_bridge: RTL and testbench
======================================

Name: cache_axi_rd_bridge

Overview:
- Downstream neighbour of the 2-way instruction cache; sits between the cache miss port and the AXI4 read channels.
- Accepts a line-refill request (rd_req/rd_addr) and issues a single 4-beat INCR burst of 32-bit words on AR/R.
- Assembles the 4 beats into a 128-bit line and returns it with a one-cycle ret_valid pulse.
- Read-only; no write channels.

Parameters:
- AXI_ID, 0, ARID driven on every request; R beats with a different RID are ignored.
- ID_W, 4, width of arid/rid.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rd_req  in  1  cache refill request, level; held until ret_valid
- rd_addr  in  32  refill address; low 4 bits ignored
- ret_valid  out  1  one-cycle pulse; ret_data valid this cycle
- ret_data  out  128  word i at bits [32i+31:32i]
- arid  out  ID_W  = AXI_ID
- araddr  out  32  {rd_addr[31:4],4'b0}
- arlen  out  8  constant 8'd3
- arsize  out  3  constant 3'b010
- arburst  out  2  constant 2'b01 (INCR)
- arvalid  out  1  AR valid
- arready  in  1  AR ready
- rid  in  ID_W  R id
- rdata  in  32  R data
- rresp  in  2  R response
- rlast  in  1  R last
- rvalid  in  1  R valid
- rready  out  1  R ready
- rd_err  out  1  sticky error (feature only; tied 0 otherwise)

Behaviour:
- States: IDLE, AR, R, DONE. All outputs are decoded from registered state and registers; there is no combinational path from inputs to outputs.
- Reset values: state=IDLE, arvalid=0, rready=0, ret_valid=0, ret_data=0, beat counter=0, araddr=0, rd_err=0.
- IDLE:
  - If rd_req: latch {rd_addr[31:4],4'b0} into araddr, clear the beat counter, go to AR.
  - Otherwise stay in IDLE.
- AR:
  - arvalid=1.
  - araddr and arid are held stable until the handshake.
  - On arready: go to R.
- R:
  - rready=1.
  - On rvalid && rid==AXI_ID: write rdata into line word[beat] and increment beat (2-bit).
  - When the accepted beat is beat==3: go to DONE.
  - Beats with a mismatched rid are accepted (rready high) but discarded.
- DONE:
  - ret_valid=1 and ret_data=assembled line, for exactly one cycle.
  - Then go to IDLE.
- ret_data holds the last line after DONE; it changes only on R beats.
- Latency:
  - rd_req sampled at cycle 0 -> arvalid at cycle 1.
  - With zero-wait arready/rvalid: beats at cycles 2–5, ret_valid at cycle 6.
  - Each stall cycle adds one cycle.
- Back-to-back requests:
  - rd_req is not sampled in DONE.
  - The cache drops rd_req the cycle after ret_valid, so the IDLE cycle after DONE never re-triggers.
  - If rd_req is still high in that IDLE cycle, a new burst is issued; this is legal.
- Only one outstanding burst exists at any time; arvalid is never high outside AR.
- Completion is count-based: rlast is ignored for sequencing and rresp is ignored (see feature).
- Reset mid-burst returns to IDLE immediately and drops partial data. The AXI slave shares rst, so no stale beats arrive.

Optional Feature:
- Macro: CACHE_AXI_RD_ERR_EN.
- With the macro defined, rd_err is set and held until rst if any accepted beat has:
  - rresp != 2'b00, or
  - rlast=1 on beats 0–2, or
  - rlast=0 on beat 3.
- The line is still returned normally with the error flagged.
- Without the macro, rd_err is tied 0 and no check logic exists.

Decomposition:
- Shared defines header (alongside the existing cache state defines):
  - state encodings BR_IDLE/BR_AR/BR_R/BR_DONE (2-bit);
  - AXI constants: ARLEN_LINE=8'd3, ARSIZE_WORD=3'b010, ARBURST_INCR=2'b01, RESP_OKAY=2'b00.
- One natural sub-module: cache_line_asm.
  - 4x32 word register plus 2-bit beat counter.
  - Inputs: clear, beat_we, rdata. Outputs: line, last_beat.
- The FSM stays in the top module.

Test Plan:
- Zero-wait refill:
  - Stimulus: rd_req=1, rd_addr=0x1FC0_0124; arready=1; beats 0x11111111, 0x22222222, 0x33333333, 0x44444444 on consecutive cycles.
  - Required: araddr=0x1FC0_0120, arlen=3, arsize=2, arburst=1; ret_valid at cycle 6; ret_data=0x44444444_33333333_22222222_11111111.
- AR backpressure:
  - Stimulus: arready low 5 cycles.
  - Required: arvalid and araddr stable throughout; no rready before the handshake; ret_valid 5 cycles later than the zero-wait case.
- R gaps and foreign ID:
  - Stimulus: rvalid toggled 1/0; one beat with rid=1 inserted.
  - Required: the foreign beat is dropped; the line is correct; ret_valid is a single-cycle pulse.
- Reset mid-burst:
  - Stimulus: rst after 2 beats.
  - Required: next cycle state=IDLE, arvalid=0, rready=0, ret_valid=0; a following request completes with correct data.
- Back-to-back refills:
  - Stimulus: two requests, 0x0000_0010 then 0x0000_0FF0.
  - Required: two distinct ARs; second ret_data correct; no extra AR issued.
- CACHE_AXI_RD_ERR_EN:
  - Stimulus: rresp=2'b10 on beat 1.
  - Required: rd_err=1 from the following cycle until rst; the line is still returned.
  - Also: rlast on beat 2 sets rd_err.

Source files
------------

// File: rtl/cache_axi_rd_bridge_pkg.sv
// Shared types and AXI constants for the instruction-cache AXI read bridge.
// Sits alongside the cache state definitions.
package cache_axi_rd_bridge_pkg;

    typedef enum logic [1:0] {
        BR_IDLE = 2'd0,
        BR_AR   = 2'd1,
        BR_R    = 2'd2,
        BR_DONE = 2'd3
    } br_state_e;

    localparam logic [7:0] ARLEN_LINE   = 8'd3;
    localparam logic [2:0] ARSIZE_WORD  = 3'b010;
    localparam logic [1:0] ARBURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY    = 2'b00;

    // 16-byte line base: drop the word/byte offset.
    function automatic logic [31:0] line_base(input logic [31:0] addr);
        return {addr[31:4], 4'b0000};
    endfunction

endpackage

// File: rtl/cache_axi_rd_bridge_if.sv
// Cache refill request/return plus AXI4 AR/R channels of the read bridge.
// master = the bridge; slave = cache and AXI slave side.
interface cache_axi_rd_bridge_if #(
    parameter int unsigned ID_W = 4
);
    logic            rd_req;
    logic [31:0]     rd_addr;
    logic            ret_valid;
    logic [127:0]    ret_data;
    logic            rd_err;

    logic [ID_W-1:0] arid;
    logic [31:0]     araddr;
    logic [7:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic            arvalid;
    logic            arready;

    logic [ID_W-1:0] rid;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rvalid;
    logic            rready;

    modport master (
        input  rd_req, rd_addr, arready, rid, rdata, rresp, rlast, rvalid,
        output ret_valid, ret_data, rd_err,
        output arid, araddr, arlen, arsize, arburst, arvalid, rready
    );

    modport slave (
        output rd_req, rd_addr, arready, rid, rdata, rresp, rlast, rvalid,
        input  ret_valid, ret_data, rd_err,
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready
    );

endinterface

// File: rtl/cache_line_asm.sv
// Assembles four 32-bit R beats into a 128-bit cache line.
// The line holds its contents between bursts; only the beat counter is cleared.
module cache_line_asm (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         beat_we,
    input  logic [31:0]  rdata,
    output logic [127:0] line,
    output logic         last_beat
);

    logic [31:0] words_q [4];
    logic [1:0]  beat_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                words_q[i] <= '0;
            end
            beat_q <= 2'd0;
        end else if (clear) begin
            beat_q <= 2'd0;
        end else if (beat_we) begin
            words_q[beat_q] <= rdata;
            beat_q          <= beat_q + 2'd1;
        end
    end

    assign line      = {words_q[3], words_q[2], words_q[1], words_q[0]};
    assign last_beat = (beat_q == 2'd3);

endmodule

// File: rtl/cache_axi_rd_bridge.sv
// Refill bridge: one 4-beat INCR AXI4 read burst per cache miss, returns a 128-bit line.
// Define CACHE_AXI_RD_ERR_EN to enable the sticky rd_err response/rlast checker.
module cache_axi_rd_bridge
    import cache_axi_rd_bridge_pkg::*;
#(
    parameter int unsigned AXI_ID = 0,
    parameter int unsigned ID_W   = 4
) (
    input logic                   clk,
    input logic                   rst,
    cache_axi_rd_bridge_if.master bus
);

    br_state_e   state_q, state_d;
    logic [31:0] araddr_q;
    logic        load_addr;
    logic        clear;
    logic        beat_we;
    logic        last_beat;
    logic        id_match;
    logic [127:0] line;

    assign id_match = (bus.rid == ID_W'(AXI_ID));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= BR_IDLE;
            araddr_q <= '0;
        end else begin
            state_q <= state_d;
            if (load_addr) begin
                araddr_q <= line_base(bus.rd_addr);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        load_addr = 1'b0;
        clear     = 1'b0;
        beat_we   = 1'b0;
        unique case (state_q)
            BR_IDLE: begin
                if (bus.rd_req) begin
                    load_addr = 1'b1;
                    clear     = 1'b1;
                    state_d   = BR_AR;
                end
            end
            BR_AR: begin
                if (bus.arready) begin
                    state_d = BR_R;
                end
            end
            BR_R: begin
                // Foreign-ID beats are still handshaken but never written.
                if (bus.rvalid && id_match) begin
                    beat_we = 1'b1;
                    if (last_beat) begin
                        state_d = BR_DONE;
                    end
                end
            end
            BR_DONE: begin
                state_d = BR_IDLE;
            end
            default: state_d = BR_IDLE;
        endcase
    end

    cache_line_asm u_line_asm (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .beat_we   (beat_we),
        .rdata     (bus.rdata),
        .line      (line),
        .last_beat (last_beat)
    );

    assign bus.arid      = ID_W'(AXI_ID);
    assign bus.araddr    = araddr_q;
    assign bus.arlen     = ARLEN_LINE;
    assign bus.arsize    = ARSIZE_WORD;
    assign bus.arburst   = ARBURST_INCR;
    assign bus.arvalid   = (state_q == BR_AR);
    assign bus.rready    = (state_q == BR_R);
    assign bus.ret_valid = (state_q == BR_DONE);
    assign bus.ret_data  = line;

`ifdef CACHE_AXI_RD_ERR_EN
    logic err_q;
    logic beat_bad;

    // rlast must coincide exactly with the fourth accepted beat.
    assign beat_bad = (bus.rresp != RESP_OKAY) || (bus.rlast != last_beat);

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (beat_we && beat_bad) begin
            err_q <= 1'b1;
        end
    end

    assign bus.rd_err = err_q;

    logic unused_addr;
    assign unused_addr = ^bus.rd_addr[3:0];
`else
    assign bus.rd_err = 1'b0;

    logic unused_in;
    assign unused_in = ^{bus.rd_addr[3:0], bus.rresp, bus.rlast};
`endif

endmodule

// File: tb/tb_cache_axi_rd_bridge.sv
// Self-checking bench for cache_axi_rd_bridge: acts as cache and AXI slave, compares
// against a line/latency model derived from the refill rules.
module tb_cache_axi_rd_bridge;
    import cache_axi_rd_bridge_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   ar_hs = 0;
    bit   exp_err = 1'b0;

    cache_axi_rd_bridge_if #(.ID_W(4)) bus ();

    cache_axi_rd_bridge #(
        .AXI_ID (0),
        .ID_W   (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && bus.arvalid && bus.arready) ar_hs <= ar_hs + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // One refill: cache request, AR handshake after ar_wait stalls, four matched beats
    // with optional idle gaps (1 = alternate, 2 = random), foreign beat and error beats.
    task automatic refill(input logic [31:0] addr, input logic [127:0] line,
                          input int ar_wait, input int gap_mode, input int foreign_at,
                          input int err_beat, input int bad_last);
        int t0, n, n_ent, lat;
        bit seen, got;
        logic [31:0] exp_addr;
        exp_addr = addr & 32'hFFFF_FFF0;
        @(negedge clk);
        bus.rd_req  = 1'b1;
        bus.rd_addr = addr;
        t0 = cyc + 1;
        n = 0; seen = 1'b0; got = 1'b0;
        for (int k = 0; k < 64 && !got; k++) begin
            @(negedge clk);
            if (!seen && bus.arvalid) begin
                seen = 1'b1;
                checks++;
                if (cyc - t0 + 1 != 1) begin
                    errors++;
                    $display("FAIL ar_latency: got cycle %0d want 1", cyc - t0 + 1);
                end
                checks++;
                if ({bus.arid, bus.arlen, bus.arsize, bus.arburst} !== {4'd0, 8'd3, 3'd2, 2'd1}) begin
                    errors++;
                    $display("FAIL ar_const: got id=%0d len=%0d size=%0d burst=%0d want 0/3/2/1",
                             bus.arid, bus.arlen, bus.arsize, bus.arburst);
                end
            end
            if (seen) begin
                checks++;
                if (bus.arvalid !== 1'b1 || bus.araddr !== exp_addr) begin
                    errors++;
                    $display("FAIL ar_stable: got arvalid=%b araddr=%h want 1 %h",
                             bus.arvalid, bus.araddr, exp_addr);
                end
                checks++;
                if (bus.rready !== 1'b0) begin
                    errors++;
                    $display("FAIL rready_in_ar: got %b want 0", bus.rready);
                end
                if (n == ar_wait) begin
                    bus.arready = 1'b1;
                    got = 1'b1;
                end else begin
                    n++;
                end
            end
        end
        if (!got) begin
            errors++;
            $display("FAIL ar_timeout: got no arvalid handshake want one");
            bus.rd_req = 1'b0;
            return;
        end
        @(negedge clk);
        bus.arready = 1'b0;
        n_ent = 0;
        for (int i = 0; i < 4; i++) begin
            if ((gap_mode == 1 && i > 0) || (gap_mode == 2 && $urandom_range(0, 1) == 1)) begin
                bus.rvalid = 1'b0;
                bus.rid    = 4'd0;
                bus.rdata  = $urandom;
                @(negedge clk);
                n_ent++;
            end
            if (foreign_at == i) begin
                bus.rvalid = 1'b1;
                bus.rid    = 4'($urandom_range(1, 15));
                bus.rdata  = $urandom;
                bus.rlast  = 1'($urandom_range(0, 1));
                bus.rresp  = 2'b00;
                @(negedge clk);
                n_ent++;
            end
            checks++;
            if (bus.rready !== 1'b1) begin
                errors++;
                $display("FAIL rready_in_r: got %b want 1 (beat %0d)", bus.rready, i);
            end
            bus.rvalid = 1'b1;
            bus.rid    = 4'd0;
            bus.rdata  = line[32*i +: 32];
            bus.rlast  = (i == 3) != (i == bad_last);
            bus.rresp  = (i == err_beat) ? 2'b10 : 2'b00;
`ifdef CACHE_AXI_RD_ERR_EN
            if (i == err_beat || i == bad_last) exp_err = 1'b1;
`endif
            @(negedge clk);
            n_ent++;
            if (i == err_beat || i == bad_last) begin
                checks++;
                if (bus.rd_err !== exp_err) begin
                    errors++;
                    $display("FAIL rd_err_set: got %b want %b (beat %0d)", bus.rd_err, exp_err, i);
                end
            end
        end
        bus.rvalid = 1'b0;
        bus.rlast  = 1'b0;
        bus.rresp  = 2'b00;
        got = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            if (bus.ret_valid === 1'b1) got = 1'b1;
            else @(negedge clk);
        end
        lat = cyc - t0 + 1;
        bus.rd_req = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL ret_timeout: got no ret_valid want pulse");
        end
        checks++;
        if (lat != 6 + ar_wait + (n_ent - 4)) begin
            errors++;
            $display("FAIL ret_latency: got %0d want %0d", lat, 6 + ar_wait + (n_ent - 4));
        end
        checks++;
        if (bus.ret_data !== line) begin
            errors++;
            $display("FAIL ret_data: got %h want %h", bus.ret_data, line);
        end
        @(negedge clk);
        checks++;
        if (bus.ret_valid !== 1'b0 || bus.ret_data !== line || bus.arvalid !== 1'b0
            || bus.rready !== 1'b0) begin
            errors++;
            $display("FAIL ret_pulse: got ret_valid=%b arvalid=%b rready=%b data=%h want 0 0 0 %h",
                     bus.ret_valid, bus.arvalid, bus.rready, bus.ret_data, line);
        end
        checks++;
        if (bus.rd_err !== exp_err) begin
            errors++;
            $display("FAIL rd_err: got %b want %b", bus.rd_err, exp_err);
        end
    endtask

    function automatic logic [127:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.arvalid !== 1'b0 || bus.rready !== 1'b0 || bus.ret_valid !== 1'b0
            || bus.ret_data !== 128'd0 || bus.araddr !== 32'd0 || bus.rd_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got arvalid=%b rready=%b ret_valid=%b araddr=%h err=%b data=%h want all 0",
                     bus.arvalid, bus.rready, bus.ret_valid, bus.araddr, bus.rd_err, bus.ret_data);
        end
        checks++;
        if (dut.state_q !== BR_IDLE) begin
            errors++;
            $display("FAIL reset_state: got %0d want %0d", dut.state_q, BR_IDLE);
        end
        rst = 1'b0;
        exp_err = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.arvalid !== 1'b0 || dut.state_q !== BR_IDLE) begin
            errors++;
            $display("FAIL idle_hold: got arvalid=%b state=%0d want 0 %0d",
                     bus.arvalid, dut.state_q, BR_IDLE);
        end
    endtask

    task automatic test_zero_wait();
        refill(32'h1FC0_0124, 128'h44444444_33333333_22222222_11111111, 0, 0, -1, -1, -1);
    endtask

    task automatic test_ar_backpressure();
        refill(32'h8000_1238, rand_line(), 5, 0, -1, -1, -1);
    endtask

    task automatic test_r_gaps_foreign();
        refill(32'h0040_00A4, rand_line(), 0, 1, 2, -1, -1);
        refill(32'h0040_00B0, rand_line(), 1, 1, 0, -1, -1);
    endtask

    task automatic test_reset_mid_burst();
        @(negedge clk);
        bus.rd_req  = 1'b1;
        bus.rd_addr = 32'h2000_0044;
        @(negedge clk);
        bus.arready = 1'b1;
        @(negedge clk);
        bus.arready = 1'b0;
        bus.rvalid  = 1'b1;
        bus.rid     = 4'd0;
        bus.rdata   = 32'hAAAA_0001;
        @(negedge clk);
        bus.rdata   = 32'hAAAA_0002;
        @(negedge clk);
        bus.rvalid  = 1'b0;
        bus.rd_req  = 1'b0;
        rst         = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_err = 1'b0;
        checks++;
        if (dut.state_q !== BR_IDLE || bus.arvalid !== 1'b0 || bus.rready !== 1'b0
            || bus.ret_valid !== 1'b0 || bus.ret_data !== 128'd0) begin
            errors++;
            $display("FAIL mid_reset: got state=%0d arvalid=%b rready=%b ret_valid=%b data=%h want idle/0",
                     dut.state_q, bus.arvalid, bus.rready, bus.ret_valid, bus.ret_data);
        end
        refill(32'h2000_0044, rand_line(), 0, 0, -1, -1, -1);
    endtask

    task automatic test_back_to_back();
        int h0;
        h0 = ar_hs;
        refill(32'h0000_0010, rand_line(), 0, 0, -1, -1, -1);
        refill(32'h0000_0FF0, rand_line(), 0, 0, -1, -1, -1);
        repeat (5) @(negedge clk);
        checks++;
        if (ar_hs != h0 + 2 || bus.arvalid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ar_count: got %0d ARs arvalid=%b want 2 0", ar_hs - h0, bus.arvalid);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 8; t++) begin
            refill($urandom, rand_line(), int'($urandom_range(0, 3)), 2,
                   ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : -1, -1, -1);
        end
    endtask

    task automatic test_error();
        refill(32'h0000_3000, rand_line(), 0, 0, -1, 1, -1);
        refill(32'h0000_3010, rand_line(), 0, 0, -1, -1, -1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_err = 1'b0;
        checks++;
        if (bus.rd_err !== 1'b0) begin
            errors++;
            $display("FAIL rd_err_clear: got %b want 0", bus.rd_err);
        end
        refill(32'h0000_3020, rand_line(), 0, 0, -1, -1, 2);
    endtask

    initial begin
        bus.rd_req  = 1'b0;
        bus.rd_addr = '0;
        bus.arready = 1'b0;
        bus.rid     = '0;
        bus.rdata   = '0;
        bus.rresp   = 2'b00;
        bus.rlast   = 1'b0;
        bus.rvalid  = 1'b0;
        test_reset();
        test_zero_wait();
        test_ar_backpressure();
        test_r_gaps_foreign();
        test_reset_mid_burst();
        test_back_to_back();
        test_random();
        test_error();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
